// File: rtl/tail_light_pkg.sv
// Shared definitions for the tail-light sequencer: mode encoding, lamp-count
// limit and the thermometer pattern generator.
package tail_light_pkg;

    localparam int MAX_LAMPS = 8;

    typedef enum logic [1:0] {
        MODE_IDLE   = 2'd0,
        MODE_LEFT   = 2'd1,
        MODE_RIGHT  = 2'd2,
        MODE_HAZARD = 2'd3
    } mode_e;

    // Low 'step' bits set; step 0 gives all lamps dark.
    function automatic logic [MAX_LAMPS-1:0] therm(input logic [3:0] step);
        logic [MAX_LAMPS-1:0] t;
        for (int i = 0; i < MAX_LAMPS; i++) begin
            t[i] = (i < int'(step));
        end
        return t;
    endfunction

endpackage

// File: rtl/tail_light_seq_tick_prescaler.sv
// Sequence-step prescaler: pulses tick_out once every TICK_DIV enabled cycles,
// restarting from zero whenever clear is asserted.
module tick_prescaler #(
    parameter int TICK_DIV = 1000000
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic tick_out
);

    localparam int              PRE_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);

    logic [PRE_W-1:0] r_pre;
    logic             w_wrap;

    assign w_wrap   = (r_pre == PRE_MAX);
    assign tick_out = enable && w_wrap;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_pre <= '0;
        end else if (clear) begin
            r_pre <= '0;
        end else if (enable) begin
            r_pre <= w_wrap ? '0 : r_pre + 1'b1;
        end
    end

endmodule

// File: rtl/tail_light_seq.sv
// Turn/brake/hazard tail-lamp sequencer with registered lamp outputs.
// Define TAIL_LIGHT_SYNC_EN to pass the four request inputs through 2-flop synchronisers.
module tail_light_seq
    import tail_light_pkg::*;
#(
    parameter int LAMPS    = 3,
    parameter int TICK_DIV = 1000000
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             left_req,
    input  logic             right_req,
    input  logic             brake,
    input  logic             hazard,
    output logic [LAMPS-1:0] left_lamps,
    output logic [LAMPS-1:0] right_lamps,
    output logic [1:0]       mode
);

    localparam int               STEP_W   = $clog2(LAMPS + 1);
    localparam logic [STEP_W-1:0] STEP_MAX = STEP_W'(LAMPS);

    logic w_left_req;
    logic w_right_req;
    logic w_brake;
    logic w_hazard;

`ifdef TAIL_LIGHT_SYNC_EN
    logic [3:0] r_sync1;
    logic [3:0] r_sync2;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= {hazard, brake, right_req, left_req};
            r_sync2 <= r_sync1;
        end
    end

    assign {w_hazard, w_brake, w_right_req, w_left_req} = r_sync2;
`else
    assign {w_hazard, w_brake, w_right_req, w_left_req} = {hazard, brake, right_req, left_req};
`endif

    mode_e              r_mode;
    mode_e              w_mode_next;
    logic               r_brake;
    logic [STEP_W-1:0]  r_step;
    logic               w_tick;
    logic               w_mode_change;
    logic               w_active;
    logic [LAMPS-1:0]   w_therm;
    logic [LAMPS-1:0]   w_brake_mask;
    logic [LAMPS-1:0]   w_left_next;
    logic [LAMPS-1:0]   w_right_next;
    logic [LAMPS-1:0]   r_left_lamps;
    logic [LAMPS-1:0]   r_right_lamps;

    always_comb begin
        w_mode_next = MODE_IDLE;
        if (w_hazard || (w_left_req && w_right_req)) begin
            w_mode_next = MODE_HAZARD;
        end else if (w_left_req) begin
            w_mode_next = MODE_LEFT;
        end else if (w_right_req) begin
            w_mode_next = MODE_RIGHT;
        end
    end

    assign w_mode_change = (w_mode_next != r_mode);
    assign w_active      = (w_mode_next != MODE_IDLE);

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clock    (clock),
        .reset_n  (reset_n),
        .clear    (w_mode_change || !w_active),
        .enable   (w_active),
        .tick_out (w_tick)
    );

    // A mode change outranks a coincident tick so each new mode starts dark.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_mode  <= MODE_IDLE;
            r_brake <= 1'b0;
            r_step  <= '0;
        end else begin
            r_mode  <= w_mode_next;
            r_brake <= w_brake;
            if (w_mode_change || !w_active) begin
                r_step <= '0;
            end else if (w_tick) begin
                r_step <= (r_step == STEP_MAX) ? '0 : r_step + 1'b1;
            end
        end
    end

    assign w_therm      = LAMPS'(therm(4'(r_step)));
    assign w_brake_mask = {LAMPS{r_brake}};

    always_comb begin
        w_left_next  = w_brake_mask;
        w_right_next = w_brake_mask;
        case (r_mode)
            MODE_LEFT:   w_left_next = w_therm;
            MODE_RIGHT:  w_right_next = w_therm;
            MODE_HAZARD: begin
                if (!r_brake) begin
                    w_left_next  = w_therm;
                    w_right_next = w_therm;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_left_lamps  <= '0;
            r_right_lamps <= '0;
        end else begin
            r_left_lamps  <= w_left_next;
            r_right_lamps <= w_right_next;
        end
    end

    assign left_lamps  = r_left_lamps;
    assign right_lamps = r_right_lamps;
    assign mode        = r_mode;

endmodule

// File: tb/tb_tail_light_seq.sv
// Randomised bench for tail_light_seq: two instances (TICK_DIV 1 and 4) checked
// every cycle against an elapsed-time reference model.
module tb_tail_light_seq;

    localparam int L = 3;

    logic         clock = 1'b0;
    logic         reset_n;
    logic         left_req;
    logic         right_req;
    logic         brake;
    logic         hazard;
    logic [L-1:0] left1;
    logic [L-1:0] right1;
    logic [L-1:0] left4;
    logic [L-1:0] right4;
    logic [1:0]   mode1;
    logic [1:0]   mode4;

    int n_checks = 0;
    int n_pass   = 0;
    int n_cycle  = 0;

    always #5 clock = ~clock;

    tail_light_seq #(.LAMPS(L), .TICK_DIV(1)) dut_div1 (
        .clock       (clock),
        .reset_n     (reset_n),
        .left_req    (left_req),
        .right_req   (right_req),
        .brake       (brake),
        .hazard      (hazard),
        .left_lamps  (left1),
        .right_lamps (right1),
        .mode        (mode1)
    );

    tail_light_seq #(.LAMPS(L), .TICK_DIV(4)) dut_div4 (
        .clock       (clock),
        .reset_n     (reset_n),
        .left_req    (left_req),
        .right_req   (right_req),
        .brake       (brake),
        .hazard      (hazard),
        .left_lamps  (left4),
        .right_lamps (right4),
        .mode        (mode4)
    );

    // Reference state: mode, brake and cycles spent in the current active mode.
    int         m_mode;
    int         m_brake;
    int         m_elapsed [2];
    int         m_left    [2];
    int         m_right   [2];
    logic [3:0] sync_q    [2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, n_cycle);
        end
    endtask

    function automatic int div_of(input int d);
        return (d == 0) ? 1 : 4;
    endfunction

    // One lamp bank: sequences when its turn mode or hazard is active, else shows brake.
    function automatic int side_pattern(input int md, input int brk, input int elapsed,
                                        input int div, input int own_mode);
        int  step;
        bit  seq;
        step = (elapsed / div) % (L + 1);
        seq  = (md == 3) || (md == own_mode);
        if (seq && !(md == 3 && brk != 0)) return (1 << step) - 1;
        return (brk != 0) ? (1 << L) - 1 : 0;
    endfunction

    task automatic model_reset();
        m_mode  = 0;
        m_brake = 0;
        for (int d = 0; d < 2; d++) begin
            m_elapsed[d] = 0;
            m_left[d]    = 0;
            m_right[d]   = 0;
        end
        sync_q[0] = '0;
        sync_q[1] = '0;
    endtask

    task automatic model_advance();
        logic [3:0] in_now;
        logic [3:0] in_eff;
        int         new_mode;
        in_now = {hazard, brake, right_req, left_req};
`ifdef TAIL_LIGHT_SYNC_EN
        in_eff    = sync_q[1];
        sync_q[1] = sync_q[0];
        sync_q[0] = in_now;
`else
        in_eff = in_now;
`endif
        if (in_eff[3] || (in_eff[0] && in_eff[1])) new_mode = 3;
        else if (in_eff[0])                        new_mode = 1;
        else if (in_eff[1])                        new_mode = 2;
        else                                       new_mode = 0;
        for (int d = 0; d < 2; d++) begin
            m_left[d]  = side_pattern(m_mode, m_brake, m_elapsed[d], div_of(d), 1);
            m_right[d] = side_pattern(m_mode, m_brake, m_elapsed[d], div_of(d), 2);
            if (new_mode != m_mode || new_mode == 0) m_elapsed[d] = 0;
            else                                     m_elapsed[d] = m_elapsed[d] + 1;
        end
        m_mode  = new_mode;
        m_brake = int'(in_eff[2]);
    endtask

    task automatic set_in(input bit l, input bit r, input bit b, input bit h);
        left_req  = l;
        right_req = r;
        brake     = b;
        hazard    = h;
    endtask

    task automatic compare_all();
        check("mode_div1",  32'(mode1),  m_mode);
        check("left_div1",  32'(left1),  m_left[0]);
        check("right_div1", 32'(right1), m_right[0]);
        check("mode_div4",  32'(mode4),  m_mode);
        check("left_div4",  32'(left4),  m_left[1]);
        check("right_div4", 32'(right4), m_right[1]);
    endtask

    task automatic run_cycle();
        @(posedge clock);
        model_advance();
        @(negedge clock);
        n_cycle++;
        compare_all();
        $display("cyc %0d in(h b r l)=%b%b%b%b mode=%0d/%0d L1=%b R1=%b L4=%b R4=%b",
                 n_cycle, hazard, brake, right_req, left_req, mode1, mode4,
                 left1, right1, left4, right4);
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) run_cycle();
    endtask

    // Asynchronous reset between clock edges; outputs must clear before any edge.
    task automatic pulse_reset();
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        check("rst_mode_div1",  32'(mode1),  0);
        check("rst_left_div1",  32'(left1),  0);
        check("rst_right_div1", 32'(right1), 0);
        check("rst_mode_div4",  32'(mode4),  0);
        check("rst_left_div4",  32'(left4),  0);
        check("rst_right_div4", 32'(right4), 0);
        $display("reset pulse at cycle %0d", n_cycle);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        set_in(0, 0, 0, 0);
        model_reset();
        @(negedge clock);
        @(negedge clock);
        compare_all();
        reset_n = 1'b1;

        set_in(1, 0, 0, 0); run_cycles(10);
        set_in(0, 0, 0, 0); run_cycles(2);
        set_in(0, 1, 1, 0); run_cycles(20);
        set_in(0, 0, 0, 1); run_cycles(3);
        set_in(0, 0, 1, 1); run_cycles(3);
        set_in(0, 0, 0, 1); run_cycles(5);
        set_in(1, 0, 0, 0); run_cycles(3);
        set_in(0, 1, 0, 0); run_cycles(6);
        set_in(1, 1, 0, 0); run_cycles(6);
        pulse_reset();
        run_cycles(8);

        for (int s = 0; s < 80; s++) begin
            int r;
            int len;
            r   = int'($urandom_range(0, 99));
            len = int'($urandom_range(1, 12));
            if (r < 6) pulse_reset();
            set_in(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0));
            run_cycles(len);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/tail_light_seq.md
# tail_light_seq

Parametrised turn-signal/brake lamp sequencer for the board-level tail-light design. Drives LAMPS lamps per side from turn, brake and hazard requests, with an internal tick prescaler, so the top level needs neither a separate clock divider nor a combinational LED-priority decode. Intended to sit directly between the switch/key inputs and the LEDR bank, with the top level mapping `left_lamps` and `right_lamps` onto LED positions.

## Interface
- LAMPS, 3: lamps per side; legal range 1..8.
- TICK_DIV, 1000000: clock cycles per sequence step; legal range ≥1. A value of 1 gives one step per cycle, for simulation.
- clock  in  1  system clock (10 MHz on board).
- reset_n  in  1  reset; one clock; reset is asynchronous and active-low.
- left_req  in  1  left turn request, level.
- right_req  in  1  right turn request, level.
- brake  in  1  brake pedal, level.
- hazard  in  1  hazard switch, level.
- left_lamps  out  LAMPS  left lamps; bit 0 is the innermost lamp.
- right_lamps  out  LAMPS  right lamps; bit 0 is the innermost lamp.
- mode  out  2  current mode: 0 IDLE, 1 LEFT, 2 RIGHT, 3 HAZARD.

## Operation
- Mode select, evaluated every cycle:
  - hazard=1, or left_req=1 and right_req=1 → HAZARD.
  - Otherwise left_req=1 → LEFT.
  - Otherwise right_req=1 → RIGHT.
  - Otherwise → IDLE.
- Prescaler counter `pre` counts 0..TICK_DIV-1.
  - `tick` = (pre == TICK_DIV-1); on tick, `pre` wraps to 0.
  - `pre` is held at 0 in IDLE.
- Step counter `step` counts 0..LAMPS.
  - In LEFT, RIGHT and HAZARD, `step` advances by 1 on each tick.
  - At LAMPS, a tick wraps it to 0, giving LAMPS+1 phases per cycle.
  - `step` is held at 0 in IDLE.
- Mode change, including IDLE→turn and LEFT↔RIGHT: `step` and `pre` both clear to 0 in the same cycle the new mode is registered.
- Sequence pattern: thermometer code `therm(step)`, with the low `step` bits set. Step 0 → all lamps off; step LAMPS → all lamps on.
- Lamp decode, applied to the registered mode, step and brake:
  - IDLE: both sides = brake ? all-ones : 0.
  - LEFT: left = therm(step); right = brake ? all-ones : 0.
  - RIGHT: right = therm(step); left = brake ? all-ones : 0.
  - HAZARD, brake=0: both sides = therm(step), in unison.
  - HAZARD, brake=1: both sides all-ones. Brake overrides hazard; `step` keeps advancing underneath.
- Changing only brake does not reset `step` or `pre`.

## Timing
- Reset values: left_lamps=0, right_lamps=0, mode=0 (IDLE); internal pre=0, step=0.
- Reset asserted mid-sequence: all outputs go to their reset values asynchronously.
- Reset release: the first active edge evaluates the inputs normally.
- Input latency, macro off: an input change sampled at edge E updates mode at E and lamps at edge E+1.
- In a turn mode entered at edge E, the first lamp lights after edge E+TICK_DIV+1.
- Full sequence period: (LAMPS+1)×TICK_DIV cycles.
- Tick coinciding with a mode change: the mode change wins; step=0 and pre=0.
- Outputs are glitch-free and fully registered.

## Configuration
- TAIL_LIGHT_SYNC_EN defined:
  - left_req, right_req, brake and hazard each pass through a 2-flop synchroniser.
  - Synchroniser flops reset to 0.
  - All input latencies grow by 2 cycles: mode at E+2, lamps at E+3.
- TAIL_LIGHT_SYNC_EN undefined: inputs are used directly; the caller guarantees they are synchronous to `clock`.

## Structure
- Package `tail_light_pkg` holds:
  - the mode encoding constants (IDLE/LEFT/RIGHT/HAZARD, 2 bits);
  - the `therm` function (step → LAMPS-bit thermometer);
  - the maximum LAMPS constant, 8.
- Sub-module `tick_prescaler`, with ports clock, reset_n, clear, enable and tick_out, parametrised by TICK_DIV. It owns `pre`.
- Step counter, mode register and lamp decode stay in `tail_light_seq`.

## Test plan
- Reset, then LAMPS=3, TICK_DIV=1, left_req=1 → left_lamps steps 000, 001, 011, 111, 000… one pattern per cycle; right_lamps=000; mode=1.
- TICK_DIV=4, right_req=1, brake=1 → left_lamps=111 throughout; right_lamps advances once every 4 cycles; period 16 cycles.
- hazard=1, then brake toggled at step 2 → both sides 111 while brake is high; when brake drops, both show therm(current step), with no step reset.
- left_req=1 with step=2, then switch to right_req=1 (left_req=0) → one cycle later left=000 and right=000, and the right sequence restarts from step 0.
- left_req=right_req=1, brake=0 → mode=3 and both sides sequence identically; reset_n pulsed low mid-sequence → outputs immediately 0, mode=0.
- With TAIL_LIGHT_SYNC_EN, TICK_DIV=1: left_req rises at edge E → mode=1 at E+2, left_lamps=001 at E+4.
